// File: rtl/fdiv_pkg.sv
//==== fdiv_pkg -- shared states, op codes and mux selects for the fdiv block | rev 1.0 ====
`default_nettype none

package fdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_INIT    = 3'd2,
    ST_MUL     = 3'd3,
    ST_SUB     = 3'd4,
    ST_ROUND   = 3'd5,
    ST_CAPTURE = 3'd6
  } state_t;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_INIT  = 6'b001100;
  localparam logic [5:0] OP_MUL   = 6'b010001;
  localparam logic [5:0] OP_SUB   = 6'b001101;
  localparam logic [5:0] OP_ROUND = 6'b100010;

  localparam logic [1:0] C1_IDLE = 2'b00;
  localparam logic [1:0] C1_INIT = 2'b01;
  localparam logic [1:0] C1_MUL  = 2'b10;
  localparam logic [1:0] C1_SUB  = 2'b11;

  typedef struct packed {
    logic [1:0] c1;
    logic [5:0] op;
    logic       rm;
  } ctl_t;

  // Datapath controls presented while the sequencer sits in a given state.
  function automatic ctl_t state_ctl(input state_t s);
    ctl_t c;
    c = '{c1: C1_IDLE, op: OP_NOP, rm: 1'b0};
    case (s)
      ST_LOAD:  c = '{c1: C1_IDLE, op: OP_LOAD,  rm: 1'b0};
      ST_INIT:  c = '{c1: C1_INIT, op: OP_INIT,  rm: 1'b0};
      ST_MUL:   c = '{c1: C1_MUL,  op: OP_MUL,   rm: 1'b0};
      ST_SUB:   c = '{c1: C1_SUB,  op: OP_SUB,   rm: 1'b0};
      ST_ROUND: c = '{c1: C1_SUB,  op: OP_ROUND, rm: 1'b1};
      default:  c = '{c1: C1_IDLE, op: OP_NOP,   rm: 1'b0};
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fdiv_ctrl.sv
//==== fdiv_ctrl -- Goldschmidt divide sequencer driving the fdiv datapath | rev 1.0 ====
`default_nettype none

module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int NUM_ITER = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] n_in,
  input  logic [31:0] d_in,
  input  logic [31:0] q_in,
  output logic [31:0] n_out,
  output logic [31:0] d_out,
  output logic [1:0]  c1,
  output logic [5:0]  op,
  output logic        rm,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  localparam logic [2:0] C_LAST = 3'(NUM_ITER - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] n_q, n_d;
  logic [31:0] d_q, d_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  ctl_t        ctl_q, ctl_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    d_d      = d_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          n_d     = n_in;
          d_d     = d_in;
          cnt_d   = 3'd0;
        end
      end
      ST_LOAD:  state_d = ST_INIT;
      ST_INIT:  state_d = ST_MUL;
      ST_MUL:   state_d = ST_SUB;
      ST_SUB: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q < C_LAST) ? ST_MUL : ST_ROUND;
      end
      ST_ROUND: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d  = ST_IDLE;
        result_d = q_in;
        valid_d  = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    // Controls are decoded from the next state so they register alongside it.
    ctl_d  = state_ctl(state_d);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      n_q      <= 32'd0;
      d_q      <= 32'd0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ctl_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      d_q      <= d_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ctl_q    <= ctl_d;
    end
  end

  assign n_out  = n_q;
  assign d_out  = d_q;
  assign c1     = ctl_q.c1;
  assign op     = ctl_q.op;
  assign rm     = ctl_q.rm;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_fdiv_ctrl.sv
//==== tb_fdiv_ctrl -- directed self-checking bench for fdiv_ctrl | rev 1.0 ====
`default_nettype none

module tb_fdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start1;
  logic [31:0] n_in, d_in, q_in, q_in1;

  logic [31:0] n_out, d_out, result;
  logic [1:0]  c1;
  logic [5:0]  op;
  logic        rm, busy, valid;

  logic [31:0] n_out1, d_out1, result1;
  logic [1:0]  c1_1;
  logic [5:0]  op1;
  logic        rm1, busy1, valid1;

  logic [10:0] obs, obs1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fdiv_ctrl #(.NUM_ITER(5)) dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in), .d_in(d_in), .q_in(q_in),
    .n_out(n_out), .d_out(d_out), .c1(c1), .op(op), .rm(rm),
    .busy(busy), .valid(valid), .result(result)
  );

  fdiv_ctrl #(.NUM_ITER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .n_in(n_in), .d_in(d_in), .q_in(q_in1),
    .n_out(n_out1), .d_out(d_out1), .c1(c1_1), .op(op1), .rm(rm1),
    .busy(busy1), .valid(valid1), .result(result1)
  );

  assign obs  = {busy, valid, c1, op, rm};
  assign obs1 = {busy1, valid1, c1_1, op1, rm1};

  // Expected {busy, valid, c1, op, rm} k cycles after the start-sampling edge.
  function automatic logic [10:0] exp_ctl(input int k, input int n);
    if (k == 0)                  return {1'b1, 1'b0, 2'b00, 6'b010000, 1'b0};
    if (k == 1)                  return {1'b1, 1'b0, 2'b01, 6'b001100, 1'b0};
    if (k >= 2 && k <= 2*n + 1) begin
      if (k % 2 == 0)            return {1'b1, 1'b0, 2'b10, 6'b010001, 1'b0};
      else                       return {1'b1, 1'b0, 2'b11, 6'b001101, 1'b0};
    end
    if (k == 2*n + 2)            return {1'b1, 1'b0, 2'b11, 6'b100010, 1'b1};
    if (k == 2*n + 3)            return {1'b1, 1'b0, 2'b00, 6'b000000, 1'b0};
    if (k == 2*n + 4)            return {1'b0, 1'b1, 2'b00, 6'b000000, 1'b0};
    return 11'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; start1 = 1'b1;
    n_in = 32'h3FC00000; d_in = 32'h3FA00000;
    step(); step();
    n_run++;
    if ({obs, n_out, d_out, result} !== 107'd0) begin
      n_fail++;
      $display("FAIL reset_state got ctl=%h n=%h d=%h r=%h want all zero", obs, n_out, d_out, result);
    end
    n_run++;
    if ({obs1, n_out1, d_out1, result1} !== 107'd0) begin
      n_fail++;
      $display("FAIL reset_state1 got ctl=%h n=%h d=%h r=%h want all zero", obs1, n_out1, d_out1, result1);
    end
    start = 1'b0; start1 = 1'b0; reset = 1'b1;
    step();
    n_run++;
    if (obs !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release got %h want 000", obs);
    end
  endtask

  task automatic test_sequence();
    n_in = 32'h3FC00000; d_in = 32'h3FA00000; q_in = 32'hDEADBEEF; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      n_run++;
      if (obs !== exp_ctl(k, 5)) begin
        n_fail++;
        $display("FAIL seq_ctl k=%0d got %h want %h", k, obs, exp_ctl(k, 5));
      end
      if (k <= 13) begin
        n_run++;
        if ({n_out, d_out} !== {32'h3FC00000, 32'h3FA00000}) begin
          n_fail++;
          $display("FAIL seq_operands k=%0d got %h/%h want 3fc00000/3fa00000", k, n_out, d_out);
        end
      end
      if (k == 14) begin
        n_run++;
        if (result !== 32'h3F99999A) begin
          n_fail++;
          $display("FAIL seq_result got %h want 3f99999a", result);
        end
      end
      q_in = (k == 13) ? 32'h3F99999A : 32'hDEADBEEF;
      step();
    end
    n_run++;
    if ({valid, result} !== {1'b0, 32'h3F99999A}) begin
      n_fail++;
      $display("FAIL seq_hold got valid=%b r=%h want 0/3f99999a", valid, result);
    end
  endtask

  task automatic test_busy_start();
    n_in = 32'h3FC00000; d_in = 32'h3FA00000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      n_run++;
      if (obs !== exp_ctl(k, 5) || (k <= 13 && n_out !== 32'h3FC00000)) begin
        n_fail++;
        $display("FAIL busy_start k=%0d got %h n=%h want %h n=3fc00000", k, obs, n_out, exp_ctl(k, 5));
      end
      start = (k == 2);
      n_in  = (k == 2) ? 32'h40000000 : 32'h3FC00000;
      q_in  = (k == 13) ? 32'h3F800000 : 32'h0BADF00D;
      step();
    end
    start = 1'b0;
    n_run++;
    if ({busy, result, n_out} !== {1'b0, 32'h3F800000, 32'h3FC00000}) begin
      n_fail++;
      $display("FAIL busy_start_end got busy=%b r=%h n=%h want 0/3f800000/3fc00000", busy, result, n_out);
    end
  endtask

  task automatic test_mid_reset();
    logic saw_valid;
    n_in = 32'h3FC00000; d_in = 32'h3FA00000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) begin
        n_run++;
        if (obs !== exp_ctl(6, 5)) begin
          n_fail++;
          $display("FAIL mid_reset_third_mul got %h want %h", obs, exp_ctl(6, 5));
        end
        reset = 1'b0;
        start = 1'b1;
      end
      step();
    end
    n_run++;
    if ({obs, n_out, d_out, result} !== 107'd0) begin
      n_fail++;
      $display("FAIL mid_reset_zero got ctl=%h n=%h d=%h r=%h want all zero", obs, n_out, d_out, result);
    end
    reset = 1'b1; start = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
      step();
    end
    n_run++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_valid got activity=1 want 0");
    end
    n_in = 32'h40400000; d_in = 32'h40000000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      n_run++;
      if (obs !== exp_ctl(k, 5)) begin
        n_fail++;
        $display("FAIL mid_reset_rerun k=%0d got %h want %h", k, obs, exp_ctl(k, 5));
      end
      q_in = (k == 13) ? 32'h3FC00000 : 32'hDEADBEEF;
      step();
    end
    n_run++;
    if (result !== 32'h3FC00000) begin
      n_fail++;
      $display("FAIL mid_reset_result got %h want 3fc00000", result);
    end
  endtask

  task automatic test_back_to_back();
    n_in = 32'h3FC00000; d_in = 32'h3FA00000; start = 1'b1;
    step();
    for (int k = 0; k <= 14; k++) begin
      n_run++;
      if (obs !== exp_ctl(k, 5)) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d got %h want %h", k, obs, exp_ctl(k, 5));
      end
      if (k == 1) begin
        n_in = 32'h41200000; d_in = 32'h40A00000;
      end
      q_in = (k == 13) ? 32'h11111111 : 32'hDEADBEEF;
      step();
    end
    start = 1'b0;
    n_run++;
    if ({obs, n_out, d_out, result} !== {exp_ctl(0, 5), 32'h41200000, 32'h40A00000, 32'h11111111}) begin
      n_fail++;
      $display("FAIL b2b_second_load got ctl=%h n=%h d=%h r=%h want %h/41200000/40a00000/11111111",
               obs, n_out, d_out, result, exp_ctl(0, 5));
    end
    q_in = 32'hDEADBEEF;
    step();
    for (int k = 1; k <= 14; k++) begin
      n_run++;
      if (obs !== exp_ctl(k, 5)) begin
        n_fail++;
        $display("FAIL b2b_second k=%0d got %h want %h", k, obs, exp_ctl(k, 5));
      end
      q_in = (k == 13) ? 32'h22222222 : 32'hDEADBEEF;
      step();
    end
    n_run++;
    if ({busy, valid, result} !== {2'b00, 32'h22222222}) begin
      n_fail++;
      $display("FAIL b2b_end got busy=%b valid=%b r=%h want 0/0/22222222", busy, valid, result);
    end
  endtask

  task automatic test_min_iter();
    n_in = 32'h40800000; d_in = 32'h40000000; start1 = 1'b1; q_in1 = 32'hDEADBEEF;
    step();
    start1 = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      n_run++;
      if (obs1 !== exp_ctl(k, 1)) begin
        n_fail++;
        $display("FAIL min_iter k=%0d got %h want %h", k, obs1, exp_ctl(k, 1));
      end
      q_in1 = (k == 5) ? 32'h40000000 : 32'hDEADBEEF;
      step();
    end
    n_run++;
    if ({valid1, result1, n_out1} !== {1'b0, 32'h40000000, 32'h40800000}) begin
      n_fail++;
      $display("FAIL min_iter_end got valid=%b r=%h n=%h want 0/40000000/40800000", valid1, result1, n_out1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    n_in = 32'd0; d_in = 32'd0; q_in = 32'd0; q_in1 = 32'd0;
    test_reset();
    test_sequence();
    test_busy_start();
    test_mid_reset();
    test_back_to_back();
    test_min_iter();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fdiv_ctrl.md
FDIV_CTRL -- requirements
Module: fdiv_ctrl

Interface
REQ-001 Parameter NUM_ITER, default 5, meaning the number of Goldschmidt MUL/SUB iteration pairs, legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  input  1  request a division; accepted only in IDLE.
REQ-005 n_in  input  32  IEEE-754 single dividend; sampled with an accepted start.
REQ-006 d_in  input  32  IEEE-754 single divisor; sampled with an accepted start.
REQ-007 q_in  input  32  quotient from the fdiv datapath Q output.
REQ-008 n_out  output  32  dividend to the datapath N input.
REQ-009 d_out  output  32  divisor to the datapath D input.
REQ-010 c1  output  2  datapath mux select.
REQ-011 op  output  6  datapath operation code.
REQ-012 rm  output  1  datapath rounding enable.
REQ-013 busy  output  1  high from the cycle after an accepted start through the CAPTURE state.
REQ-014 valid  output  1  one-cycle pulse marking result as newly updated.
REQ-015 result  output  32  captured quotient, held until the next capture.

Function
REQ-016 States, in order: IDLE, LOAD, INIT, MUL, SUB, ROUND, CAPTURE; each state lasts exactly one cycle except IDLE.
REQ-017 The state outputs SHALL be:
- IDLE: c1=00, op=000000, rm=0
- LOAD: c1=00, op=010000, rm=0
- INIT: c1=01, op=001100, rm=0
- MUL: c1=10, op=010001, rm=0
- SUB: c1=11, op=001101, rm=0
- ROUND: c1=11, op=100010, rm=1
- CAPTURE: c1=00, op=000000, rm=0
REQ-018 IDLE with start=1 SHALL go to LOAD, load n_in/d_in into n_out/d_out, and clear the iteration counter.
REQ-019 Transitions SHALL be:
- LOAD->INIT
- INIT->MUL
- MUL->SUB
- SUB->MUL if counter<NUM_ITER-1, else ROUND; the counter increments on each SUB exit
- ROUND->CAPTURE
- CAPTURE->IDLE
REQ-020 On the CAPTURE exit edge, result SHALL load q_in and valid SHALL be registered high for exactly one cycle.
REQ-021 Latency: valid is high in the cycle following edge number 4+2*NUM_ITER, counting the start-sampling edge as 0 (14 for NUM_ITER=5).
REQ-022 start while not in IDLE SHALL be ignored; n_out/d_out SHALL stay stable from LOAD through CAPTURE.
REQ-023 start in the cycle valid is high (state IDLE) SHALL be accepted, giving back-to-back operation with no bubble.
REQ-024 The counter is 3 bits and SHALL never wrap, given legal NUM_ITER.

Reset
REQ-025 With reset=0 at a rising edge, the block SHALL return to IDLE with c1=00, op=000000, rm=0, busy=0, valid=0, result=0, n_out=0, d_out=0, counter=0, regardless of current state.
REQ-026 A reset mid-operation SHALL discard the operation with no valid pulse; start is ignored while reset=0.

Structure
REQ-027 Package fdiv_pkg SHALL hold the state enum, the op constants (OP_NOP, OP_LOAD, OP_INIT, OP_MUL, OP_SUB, OP_ROUND) and the c1 constants, for reuse by the fdiv datapath and benches.
REQ-028 The block is a single module with no sub-module; the counter and the operand/result registers are inline.

Verification
REQ-029 Sequence check: NUM_ITER=5, start with n_in=0x3FC00000, d_in=0x3FA00000.
- Required: LOAD, INIT, then 5x (MUL, SUB), ROUND, CAPTURE, with the exact c1/op/rm values per cycle.
- Required: valid at cycle 14.
REQ-030 Capture check: in the same run, the bench model drives q_in=0x3F99999A during CAPTURE.
- Required: result=0x3F99999A with a one-cycle valid pulse.
- Required: result holds after q_in changes.
REQ-031 Busy start: start asserted in MUL with n_in=0x40000000.
- Required: ignored; n_out stays 0x3FC00000 and the sequence is unchanged.
REQ-032 Mid-operation reset: reset=0 during the third MUL.
- Required: next cycle in IDLE with all outputs zero and no valid pulse; a following start runs a full sequence.
REQ-033 Back-to-back: start held high through valid.
- Required: the second LOAD follows in the cycle after valid, and valid pulses again 14 cycles later.
REQ-034 Minimum iterations: NUM_ITER=1.
- Required: sequence LOAD, INIT, MUL, SUB, ROUND, CAPTURE with valid at cycle 6.
